// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - repeating serial pattern generator with inter-frame gaps
module seq_gen #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1001,
  parameter logic               IDLE_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic [2:0] gap,
  output logic       data,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  // Pattern widened to 8 bits so a 3-bit index always lands in range.
  localparam logic [7:0] P_PAT = 8'(PATTERN);
  localparam logic [2:0] P_MSB = 3'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FIN
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit;
  logic [3:0] r_rep;
  logic [2:0] r_gap_len;
  logic [2:0] r_gap_cnt;
  logic       r_data;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;

  state_t     w_state;
  logic [2:0] w_bit;
  logic [3:0] w_rep;
  logic [2:0] w_gap_len;
  logic [2:0] w_gap_cnt;
  logic       w_data;
  logic       w_valid;
  logic       w_busy;
  logic       w_done;
  logic [2:0] w_bit_dec;

  assign w_bit_dec = r_bit - 3'd1;

  // Next-state logic; outputs are computed one cycle ahead so they can be registered.
  always_comb begin
    w_state   = r_state;
    w_bit     = r_bit;
    w_rep     = r_rep;
    w_gap_len = r_gap_len;
    w_gap_cnt = r_gap_cnt;
    w_data    = IDLE_BIT;
    w_valid   = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (count != 4'd0)) begin
          w_state   = S_SEND;
          w_rep     = count;
          w_gap_len = gap;
          w_bit     = P_MSB;
          w_data    = P_PAT[P_MSB];
          w_valid   = 1'b1;
          w_busy    = 1'b1;
        end
      end
      S_SEND: begin
        if (r_bit != 3'd0) begin
          w_bit   = w_bit_dec;
          w_data  = P_PAT[w_bit_dec];
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end else if (r_rep != 4'd1) begin
          // Frame finished with more repetitions pending.
          w_rep  = r_rep - 4'd1;
          w_busy = 1'b1;
          if (r_gap_len != 3'd0) begin
            w_state   = S_GAP;
            w_gap_cnt = r_gap_len;
          end else begin
            w_bit   = P_MSB;
            w_data  = P_PAT[P_MSB];
            w_valid = 1'b1;
          end
        end else begin
          w_rep   = 4'd0;
          w_state = S_FIN;
          w_done  = 1'b1;
        end
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (r_gap_cnt == 3'd1) begin
          w_gap_cnt = 3'd0;
          w_state   = S_SEND;
          w_bit     = P_MSB;
          w_data    = P_PAT[P_MSB];
          w_valid   = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt - 3'd1;
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit     <= 3'd0;
      r_rep     <= 4'd0;
      r_gap_len <= 3'd0;
      r_gap_cnt <= 3'd0;
      r_data    <= IDLE_BIT;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_bit     <= w_bit;
      r_rep     <= w_rep;
      r_gap_len <= w_gap_len;
      r_gap_cnt <= w_gap_cnt;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - scoreboard bench for seq_gen
module tb_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic [2:0] gap;
  logic       data;
  logic       valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  // Expected {data, valid, busy, done} for each active output cycle.
  logic [3:0] exp_q[$];

  seq_gen dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .count(count),
    .gap  (gap),
    .data (data),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle with any activity must match the head of the queue.
  initial begin
    logic [3:0] e;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      if (valid || busy || done) begin
        a = {data, valid, busy, done};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_unexpected: got d/v/b/o=%b, required no activity", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL stream: got d/v/b/o=%b, required %b", a, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // '1'/'0' pattern bit, '_' gap cycle, 'D' done cycle.
  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "1":     exp_q.push_back(4'b1110);
        "0":     exp_q.push_back(4'b0110);
        "_":     exp_q.push_back(4'b0010);
        default: exp_q.push_back(4'b0001);
      endcase
    end
  endtask

  task automatic wait_done(input int exp_busy, input int poke_at, input bit fin_poke);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      if (nb == poke_at) begin
        start = 1'b1;
        count = 4'd7;
        gap   = 3'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("busy_cycles", nb, exp_busy);
    if (fin_poke) begin
      start = 1'b1;
      count = 4'd3;
      gap   = 3'd0;
    end
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_xfer(input logic [3:0] c, input logic [2:0] g, input string s,
                          input int exp_busy, input int poke_at, input bit fin_poke);
    expect_str(s);
    count = c;
    gap   = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(exp_busy, poke_at, fin_poke);
  endtask

  initial begin
    string big;
    rst   = 1'b1;
    start = 1'b1;
    count = 4'd1;
    gap   = 3'd0;
    tick();
    tick();
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // Start held through reset is taken in the first cycle after release.
    expect_str("1001D");
    rst = 1'b0;
    tick();
    start = 1'b0;
    wait_done(4, -1, 1'b0);

    // count==0 is ignored.
    count = 4'd0;
    gap   = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("cnt0_busy", int'(busy), 0);
    chk("cnt0_done", int'(done), 0);

    // Gap of 3, with start and changed count/gap during SEND.
    run_xfer(4'd2, 3'd3, "1001___1001D", 11, 3, 1'b0);

    // Back-to-back frames, start poked in the FIN cycle.
    run_xfer(4'd3, 3'd0, "100110011001D", 12, -1, 1'b1);

    // Reset during bit 2 of frame 2.
    expect_str("100110");
    count = 4'd2;
    gap   = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_data", int'(data), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_queue", exp_q.size(), 0);
    exp_q.delete();
    tick();
    run_xfer(4'd1, 3'd0, "1001D", 4, -1, 1'b0);

    // Maximum count and gap.
    big = "";
    for (int i = 0; i < 15; i++) begin
      big = {big, "1001"};
      if (i < 14) big = {big, "_______"};
    end
    big = {big, "D"};
    run_xfer(4'd15, 3'd7, big, 158, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PAT_LEN, default 4, number of bits in one pattern frame (legal 2..8).
REQ-002 Parameter PATTERN, default 4'b1001, frame bit pattern, transmitted MSB first.
REQ-003 Parameter IDLE_BIT, default 1'b0, line level driven on data whenever valid is low.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 count  input  4  number of frame repetitions to send; captured on accepted start.
REQ-008 gap  input  3  idle bit-times inserted between consecutive frames; captured on accepted start.
REQ-009 data  output  1  serial bit stream, registered.
REQ-010 valid  output  1  high while data carries a pattern bit, registered.
REQ-011 busy  output  1  high from the cycle after an accepted start until the cycle done is high, registered.
REQ-012 done  output  1  one-cycle completion pulse, registered.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SEND, GAP and FIN.
REQ-014 In IDLE, start=1 with count!=0 SHALL be accepted: count and gap are latched, the bit index is set to PAT_LEN-1, and the next state is SEND.
REQ-015 In IDLE, start=1 with count==0 SHALL be ignored: no state change, done stays 0.
REQ-016 start SHALL be ignored in SEND, GAP and FIN.
REQ-017 Latency: the first frame bit (PATTERN[PAT_LEN-1]) SHALL appear on data with valid=1 in the cycle after start is accepted.
REQ-018 In SEND, one bit SHALL be driven per cycle, descending from index PAT_LEN-1 to 0, with valid=1 and busy=1.
REQ-019 After bit 0, if repetitions remain and latched gap!=0, the FSM SHALL enter GAP for exactly gap cycles with data=IDLE_BIT, valid=0, busy=1.
REQ-020 After bit 0, if repetitions remain and latched gap==0, the next frame's MSB SHALL follow in the very next cycle, with no idle bit.
REQ-021 After bit 0 of the last repetition, the FSM SHALL enter FIN for one cycle with done=1, busy=0, valid=0, data=IDLE_BIT, then return to IDLE.
REQ-022 The repetition counter SHALL decrement once per completed frame; count=15 SHALL yield exactly 15 frames, with no wrap-around.
REQ-023 The gap counter SHALL reload from the latched gap for every inter-frame gap; there SHALL be no gap after the last frame.
REQ-024 A change on count or gap while busy SHALL NOT affect the transfer in progress.
REQ-025 A start asserted in the FIN cycle SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-026 Total transfer length SHALL be count*PAT_LEN + (count-1)*gap cycles of busy=1, followed by the 1 FIN cycle.

Reset
REQ-027 When rst=1 at a posedge, the block SHALL enter IDLE with data=IDLE_BIT, valid=0, busy=0, done=0, and all counters cleared.
REQ-028 rst SHALL take priority over start and over any state, including mid-frame and mid-gap; the partial frame is abandoned with no done pulse.
REQ-029 A start held high together with rst SHALL be ignored; it is accepted in the first cycle after rst falls if it is still high.

Verification
REQ-030 Single frame: start=1 for one cycle, count=1, gap=0 -> data=1,0,0,1 with valid=1 over cycles 1-4, then done=1 in cycle 5, busy=0 from cycle 5.
REQ-031 Repeat with gap: count=2, gap=3 -> data/valid 1001 (valid=1), 000 (valid=0), 1001 (valid=1), then done; busy high for 11 cycles.
REQ-032 Back-to-back frames: count=3, gap=0 -> 12 consecutive valid bits 100110011001, then one done pulse.
REQ-033 Ignored requests: start with count=0 -> no activity; start pulsed during SEND and during FIN -> stream and done timing unchanged.
REQ-034 Reset mid-operation: rst=1 during bit 2 of frame 2 -> next cycle valid=0, busy=0, done=0, data=0; a later start=1, count=1 -> a clean 1001 frame.
REQ-035 Max count: count=15, gap=7 -> exactly 15 frames and 14 gaps, busy high for 158 cycles, and a single done pulse.
